// File: rtl/matrix_stream_loader.sv
// Streams eight Q2.14 operands into a 2x2 multiplier, then streams its four results back out.
// Optional MLOAD_ERR_EN adds in_last framing checks and a sticky err flag.
module matrix_stream_loader #(
  parameter int unsigned CAPTURE_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a00,
  output logic [15:0] a01,
  output logic [15:0] a10,
  output logic [15:0] a11,
  output logic [15:0] b00,
  output logic [15:0] b01,
  output logic [15:0] b10,
  output logic [15:0] b11,
  input  logic [15:0] c00,
  input  logic [15:0] c01,
  input  logic [15:0] c10,
  input  logic [15:0] c11,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
`ifdef MLOAD_ERR_EN
  ,
  input  logic        in_last,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    LOAD,
    WAIT,
    SEND
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  idx;
  logic [3:0]  cnt;
  logic [1:0]  sidx;
  logic [15:0] op  [8];
  logic [15:0] res [4];
  logic        accept;
  logic        frame_err;
  logic        cap_done;
  logic        send_done;

  assign accept    = in_valid && in_ready;
  assign cap_done  = (state == WAIT) && (cnt == 4'(CAPTURE_DELAY - 1));
  assign send_done = out_valid && out_ready && (sidx == 2'd3);

`ifdef MLOAD_ERR_EN
  assign frame_err = accept && (in_last != (idx == 3'd7));
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD: if (accept && !frame_err && idx == 3'd7) state_n = WAIT;
      WAIT: if (cap_done) state_n = SEND;
      SEND: if (send_done) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      sidx <= '0;
      for (int i = 0; i < 8; i++) op[i] <= '0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      // A misframed word drops the whole frame; earlier words get overwritten next time
      if (accept) begin
        if (frame_err) begin
          idx <= '0;
        end else begin
          op[idx] <= in_data;
          idx     <= idx + 3'd1;
        end
      end
      if (state != WAIT)  cnt <= '0;
      else if (!cap_done) cnt <= cnt + 4'd1;
      if (cap_done) begin
        res[0] <= c00;
        res[1] <= c01;
        res[2] <= c10;
        res[3] <= c11;
      end
      if (out_valid && out_ready) sidx <= sidx + 2'd1;
    end
  end

`ifdef MLOAD_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err <= 1'b0;
    else if (frame_err) err <= 1'b1;
  end
`endif

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (sidx == 2'd3);
  assign out_data  = out_valid ? res[sidx] : '0;

  assign a00 = op[0];
  assign a01 = op[1];
  assign a10 = op[2];
  assign a11 = op[3];
  assign b00 = op[4];
  assign b01 = op[5];
  assign b10 = op[6];
  assign b11 = op[7];

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader with a behavioural 2x2 Q2.14 multiplier.
// Framing-error scenario is built only when MLOAD_ERR_EN is defined.
module tb_matrix_stream_loader;

  localparam int D = 3;

  typedef logic [15:0] vec8_t [8];
  typedef logic [15:0] vec4_t [4];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] a00, a01, a10, a11;
  logic [15:0] b00, b01, b10, b11;
  logic [15:0] c00, c01, c10, c11;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef MLOAD_ERR_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(.CAPTURE_DELAY(D)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef MLOAD_ERR_EN
    , .in_last(in_last), .err(err)
`endif
  );

  function automatic logic [15:0] mac(
    input logic signed [15:0] x0, input logic signed [15:0] y0,
    input logic signed [15:0] x1, input logic signed [15:0] y1);
    logic signed [31:0] s;
    s = 32'(x0) * 32'(y0) + 32'(x1) * 32'(y1);
    return s[29:14];
  endfunction

  always_comb begin
    c00 = mac(a00, b00, a01, b10);
    c01 = mac(a00, b01, a01, b11);
    c10 = mac(a10, b00, a11, b10);
    c11 = mac(a10, b01, a11, b11);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_words(input vec8_t w, input int n, input int bad_at);
    for (int i = 0; i < n; i++) begin
      in_data  = w[i];
      in_valid = 1'b1;
      in_last  = (i == 7) || (i == bad_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_no_output(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic run_txn(input string tag, input vec8_t w,
                         input vec4_t e, input bit bp);
    int lat;
    load_words(w, 8, -1);
    check({tag, "_a00"}, a00, w[0]);
    check({tag, "_b11"}, b11, w[7]);
    if (bp) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, D);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_d%0d", tag, k), out_data, e[k]);
      check($sformatf("%s_v%0d", tag, k), out_valid, 1'b1);
      check($sformatf("%s_l%0d", tag, k), out_last, k == 3);
      if (bp && k == 1) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(posedge clk); #1;
          check($sformatf("%s_hold%0d", tag, h), out_data, e[1]);
          check($sformatf("%s_holdv%0d", tag, h), out_valid, 1'b1);
          check($sformatf("%s_holdr%0d", tag, h), in_ready, 1'b0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({tag, "_rdy"}, in_ready, 1'b1);
    check({tag, "_idle"}, out_valid, 1'b0);
    check({tag, "_keep"}, a00, w[0]);
  endtask

  vec8_t w_id, w_sc, w_mx, w_junk;
  vec4_t e_id, e_sc, e_mx;

  initial begin
    w_id   = '{16'h4000, 16'h0000, 16'h0000, 16'h4000,
               16'h2000, 16'h1000, 16'hF000, 16'h4000};
    e_id   = '{16'h2000, 16'h1000, 16'hF000, 16'h4000};
    w_sc   = '{16'h2000, 16'h0000, 16'h0000, 16'h2000,
               16'h2000, 16'h0000, 16'h0000, 16'h2000};
    e_sc   = '{16'h1000, 16'h0000, 16'h0000, 16'h1000};
    w_mx   = '{16'h2000, 16'h4000, 16'hE000, 16'h1000,
               16'h4000, 16'h2000, 16'h1000, 16'hC000};
    e_mx   = '{16'h3000, 16'hD000, 16'hE400, 16'hE000};
    w_junk = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
               16'h5555, 16'h6666, 16'h7777, 16'h8888};

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oval", out_valid, 1'b0);
    check("rst_olast", out_last, 1'b0);
    check("rst_odata", out_data, 16'h0);
    check("rst_a00", a00, 16'h0);
    check("rst_b11", b11, 16'h0);
`ifdef MLOAD_ERR_EN
    check("rst_err", err, 1'b0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rdy", in_ready, 1'b1);

    run_txn("ident", w_id, e_id, 1'b0);
    run_txn("scalar", w_sc, e_sc, 1'b0);
    run_txn("bp", w_mx, e_mx, 1'b1);

    load_words(w_junk, 5, -1);
    #2 rst = 1'b1;
    #1;
    check("mid_oval", out_valid, 1'b0);
    check("mid_a00", a00, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rdy", in_ready, 1'b1);
    idle_no_output("mid_noout", 20);
    run_txn("after_rst", w_sc, e_sc, 1'b0);

`ifdef MLOAD_ERR_EN
    load_words(w_junk, 3, 2);
    check("err_set", err, 1'b1);
    idle_no_output("err_noout", 20);
    run_txn("after_err", w_id, e_id, 1'b0);
    check("err_sticky", err, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
